// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM state type and the
// default geometry / vector locations.
package pc_pkg;

   localparam int unsigned PC_ADDR_W = 32;
   localparam int unsigned PC_WORD_W = 16;

   localparam logic [31:0] PC_RESET_VEC_ADDR = 32'h0000_0000;
   localparam logic [31:0] PC_INT_VEC_ADDR   = 32'h0000_0002;

   typedef enum logic [2:0] {
      RST_HI,
      RST_LO,
      RUN,
      INT_HI,
      INT_LO
   } pc_state_t;

endpackage

// File: rtl/pc_vec_loader.sv
// Two-word (HI then LO) vector fetch datapath shared by the reset and
// interrupt paths: drives the read request and merges returned words into the PC.
module pc_vec_loader
   import pc_pkg::*;
#(
   parameter int unsigned           ADDR_W         = PC_ADDR_W,
   parameter int unsigned           WORD_W         = PC_WORD_W,
   parameter logic [ADDR_W-1:0]     RESET_VEC_ADDR = ADDR_W'(PC_RESET_VEC_ADDR),
   parameter logic [ADDR_W-1:0]     INT_VEC_ADDR   = ADDR_W'(PC_INT_VEC_ADDR)
) (
   input  logic              active,
   input  logic              lo_phase,
   input  logic              int_path,
   input  logic              mem_valid,
   input  logic [WORD_W-1:0] mem_data,
   input  logic [ADDR_W-1:0] cur_pc,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              advance,
   output logic [ADDR_W-1:0] load_pc
);

   logic [ADDR_W-1:0] base_addr;

   assign base_addr = int_path ? INT_VEC_ADDR : RESET_VEC_ADDR;

   always_comb begin
      mem_rd   = 1'b0;
      mem_addr = '0;
      advance  = 1'b0;
      load_pc  = cur_pc;
      if (active) begin
         mem_rd   = 1'b1;
         mem_addr = base_addr + ADDR_W'(lo_phase);
         advance  = mem_valid;
         // The half not being written is kept from the current PC, so the
         // HI word survives in the PC register until the LO word arrives.
         if (mem_valid) begin
            if (lo_phase) begin
               load_pc = {cur_pc[ADDR_W-1:WORD_W], mem_data};
            end else begin
               load_pc = {mem_data, cur_pc[WORD_W-1:0]};
            end
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: loads the reset/interrupt vectors from memory, then
// sequences the fetch PC with redirect, stall and interrupt handling.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned           ADDR_W         = PC_ADDR_W,
   parameter int unsigned           WORD_W         = PC_WORD_W,
   parameter logic [ADDR_W-1:0]     RESET_VEC_ADDR = ADDR_W'(PC_RESET_VEC_ADDR),
   parameter logic [ADDR_W-1:0]     INT_VEC_ADDR   = ADDR_W'(PC_INT_VEC_ADDR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              instr_len2,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              int_req,
   input  logic [WORD_W-1:0] mem_data,
   input  logic              mem_valid,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   output logic              int_ack,
   output logic [ADDR_W-1:0] saved_pc
);

   if (ADDR_W != 2 * WORD_W) begin : g_width_check
      $error("pc_unit: ADDR_W must equal 2*WORD_W");
   end

   pc_state_t         state;
   pc_state_t         state_next;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] saved_next;
   logic [ADDR_W-1:0] pc_incr;
   logic              vec_active;
   logic              vec_lo;
   logic              vec_int;
   logic              vec_advance;
   logic [ADDR_W-1:0] vec_pc;

   assign vec_active = (state != RUN);
   assign vec_lo     = (state == RST_LO) || (state == INT_LO);
   assign vec_int    = (state == INT_HI) || (state == INT_LO);
   assign pc_valid   = (state == RUN);
   assign pc_incr    = pc + (instr_len2 ? ADDR_W'(2) : ADDR_W'(1));

   pc_vec_loader #(
      .ADDR_W         (ADDR_W),
      .WORD_W         (WORD_W),
      .RESET_VEC_ADDR (RESET_VEC_ADDR),
      .INT_VEC_ADDR   (INT_VEC_ADDR)
   ) u_vec_loader (
      .active    (vec_active),
      .lo_phase  (vec_lo),
      .int_path  (vec_int),
      .mem_valid (mem_valid),
      .mem_data  (mem_data),
      .cur_pc    (pc),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .advance   (vec_advance),
      .load_pc   (vec_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RST_HI;
         pc       <= '0;
         saved_pc <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         saved_pc <= saved_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      saved_next = saved_pc;
      int_ack    = 1'b0;
      unique case (state)
         RST_HI: begin
            pc_next = vec_pc;
            if (vec_advance) state_next = RST_LO;
         end
         RST_LO: begin
            pc_next = vec_pc;
            if (vec_advance) state_next = RUN;
         end
         INT_HI: begin
            pc_next = vec_pc;
            if (vec_advance) state_next = INT_LO;
         end
         INT_LO: begin
            pc_next = vec_pc;
            if (vec_advance) state_next = RUN;
         end
         RUN: begin
            // Accept captures where execution would have continued; the PC
            // itself is about to be replaced by the interrupt vector.
            if (int_req && !stall) begin
               int_ack    = 1'b1;
               saved_next = redirect ? redirect_pc : pc_incr;
               state_next = INT_HI;
            end else if (redirect) begin
               pc_next = redirect_pc;
            end else if (!stall) begin
               pc_next = pc_incr;
            end
         end
         default: begin
            state_next = RST_HI;
         end
      endcase
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 32, PC width.
- WORD_W, 16, memory word width; ADDR_W = 2*WORD_W enforced by elaboration check.
- RESET_VEC_ADDR, 0, address of reset-vector high word.
- INT_VEC_ADDR, 2, address of interrupt-vector high word.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- stall, in, 1: hold PC.
- instr_len2, in, 1: current instruction is 2 words.
- redirect, in, 1: branch/jump/return taken.
- redirect_pc, in, ADDR_W: redirect target.
- int_req, in, 1: interrupt request level.
- mem_data, in, WORD_W: vector word read data.
- mem_valid, in, 1: mem_data valid this cycle.
- mem_rd, out, 1: vector read request.
- mem_addr, out, ADDR_W: vector read address.
- pc, out, ADDR_W: current fetch PC.
- pc_valid, out, 1: pc usable for fetch.
- int_ack, out, 1: one-cycle interrupt acceptance pulse.
- saved_pc, out, ADDR_W: return address captured at interrupt.

Function
REQ-003 FSM states SHALL be RST_HI, RST_LO, RUN, INT_HI, INT_LO.
REQ-004 In RST_HI/RST_LO/INT_HI/INT_LO, mem_rd SHALL be 1 and pc_valid 0; in RUN, mem_rd SHALL be 0 and pc_valid 1.
REQ-005 mem_addr SHALL be RESET_VEC_ADDR in RST_HI, RESET_VEC_ADDR+1 in RST_LO, INT_VEC_ADDR in INT_HI, INT_VEC_ADDR+1 in INT_LO, and 0 in RUN.
REQ-006 In an *_HI state, mem_valid SHALL latch mem_data into pc[ADDR_W-1:WORD_W] and advance to the matching *_LO state; without mem_valid the state SHALL hold indefinitely.
REQ-007 In an *_LO state, mem_valid SHALL latch mem_data into pc[WORD_W-1:0] and advance to RUN; pc_valid SHALL rise the cycle after the low-word handshake.
REQ-008 In RUN, next-PC priority SHALL be interrupt accept, then redirect (pc <= redirect_pc), then stall (hold), then increment (pc + 1, or pc + 2 when instr_len2).
REQ-009 Interrupt accept SHALL occur in RUN when int_req=1 and stall=0; int_ack pulses that cycle and the state goes to INT_HI.
REQ-010 On accept, saved_pc SHALL be redirect_pc if redirect=1, else pc+1 or pc+2 per instr_len2.
REQ-011 redirect SHALL override stall in RUN; stall SHALL defer interrupt acceptance.
REQ-012 Outside RUN, stall, redirect and int_req SHALL be ignored; an int_req still high on return to RUN SHALL be accepted again.
REQ-013 Increment SHALL wrap modulo 2^ADDR_W (0xFFFFFFFF + 1 = 0x00000000; 0xFFFFFFFF + 2 = 0x00000001).
REQ-014 saved_pc SHALL hold its value until the next accept.
REQ-015 int_ack SHALL never be high on two consecutive cycles.

Reset
REQ-016 rst=0 SHALL immediately, without waiting for clk, force state RST_HI, pc=0, saved_pc=0, int_ack=0, pc_valid=0, mem_rd=1, mem_addr=RESET_VEC_ADDR.
REQ-017 Reset asserted mid-vector-fetch or mid-RUN SHALL abandon the operation; any partially loaded vector SHALL be discarded.
REQ-018 After rst deasserts, the first state transition SHALL occur at the first rising clk edge with mem_valid=1.

Structure
REQ-019 Package pc_pkg SHALL hold the FSM state type and the default ADDR_W, WORD_W, RESET_VEC_ADDR and INT_VEC_ADDR constants.
REQ-020 The two-word HI/LO vector load SHALL be a single sub-module, pc_vec_loader, shared by the reset and interrupt paths.

Verification
REQ-021 Reset vector: release rst; mem returns 0x0000 then 0x0100 with mem_valid -> pc=0x00000100, pc_valid=1 one cycle after the second handshake.
REQ-022 Sequencing from pc=0x100: len1, len2, stall, len1 -> pc 0x101, 0x103, 0x103, 0x104; redirect with redirect_pc=0x2000 plus stall -> pc=0x2000.
REQ-023 Interrupt at pc=0x200 with instr_len2=1 -> int_ack one cycle, saved_pc=0x202; vector 0x0000/0x0300 -> pc=0x300 in RUN.
REQ-024 Interrupt coincident with redirect to 0x400 -> saved_pc=0x400; with stall=1 -> no int_ack until stall drops.
REQ-025 Wrap: pc=0xFFFFFFFF, len2 -> pc=0x00000001.
REQ-026 rst pulled low between HI and LO handshakes -> immediate pc=0, RST_HI, mem_addr=RESET_VEC_ADDR; full reload succeeds after release.
